// File: rtl/bus_codes_pkg.sv
// Shared bus codes for the 32-source datapath bus: widths, destination/source
// codes, read-only mask and the loader state type.
package bus_codes_pkg;
  localparam int DATA_W   = 32;
  localparam int SEL_W    = 5;
  localparam int NUM_DEST = 32;

  localparam logic [SEL_W-1:0] CODE_R0  = 5'd0,  CODE_R1  = 5'd1,  CODE_R2  = 5'd2,  CODE_R3  = 5'd3;
  localparam logic [SEL_W-1:0] CODE_R4  = 5'd4,  CODE_R5  = 5'd5,  CODE_R6  = 5'd6,  CODE_R7  = 5'd7;
  localparam logic [SEL_W-1:0] CODE_R8  = 5'd8,  CODE_R9  = 5'd9,  CODE_R10 = 5'd10, CODE_R11 = 5'd11;
  localparam logic [SEL_W-1:0] CODE_R12 = 5'd12, CODE_R13 = 5'd13, CODE_R14 = 5'd14, CODE_R15 = 5'd15;
  localparam logic [SEL_W-1:0] CODE_HI  = 5'd16, CODE_LO  = 5'd17, CODE_ZHI = 5'd18, CODE_ZLO = 5'd19;
  localparam logic [SEL_W-1:0] CODE_PC  = 5'd20, CODE_MDR = 5'd21, CODE_INPORT = 5'd22, CODE_C = 5'd23;
  localparam logic [SEL_W-1:0] CODE_R24 = 5'd24, CODE_R25 = 5'd25, CODE_R26 = 5'd26, CODE_R27 = 5'd27;
  localparam logic [SEL_W-1:0] CODE_R28 = 5'd28, CODE_R29 = 5'd29, CODE_R30 = 5'd30, CODE_R31 = 5'd31;

  // ZHI, ZLO, InPort and C are owned by other units and never loaded from the bus
  localparam logic [NUM_DEST-1:0] RO_MASK_DEF = 32'h00CC_0000;

  typedef enum logic {IDLE, PEND} state_e;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } pend_t;
endpackage

// File: rtl/bus_dest_loader_if.sv
// Write-side handshake bundle of the bus destination loader.
interface bus_dest_loader_if #(parameter int DATA_W = 32, parameter int SEL_W = 5);
  logic [DATA_W-1:0] bus_data;
  logic              wr_valid;
  logic [SEL_W-1:0]  wr_sel;
  logic              wr_ready;
  logic              hold;
  logic              wr_err;
  logic              busy;

  modport master (output bus_data, wr_valid, wr_sel, hold, input wr_ready, wr_err, busy);
  modport slave  (input bus_data, wr_valid, wr_sel, hold, output wr_ready, wr_err, busy);
endinterface

// File: rtl/bus_dest_loader_decoder_5_32.sv
// 5-to-32 one-hot load-enable decode of the pending destination, gated by commit.
module decoder_5_32
  import bus_codes_pkg::*;
(
  input  logic [SEL_W-1:0]    sel,
  input  logic                en,
  output logic [NUM_DEST-1:0] ld
);
  always_comb begin
    ld = '0;
    if (en) ld[sel] = 1'b1;
  end
endmodule

// File: rtl/bus_dest_loader.sv
// Bus destination loader: one-entry pending stage feeding 32 destination registers.
// Optional BUS_DEST_R0_ZERO_EN makes R0 a constant-zero register.
module bus_dest_loader
  import bus_codes_pkg::*;
#(
  parameter logic [NUM_DEST-1:0] RO_MASK = RO_MASK_DEF
) (
  input  logic                             clk,
  input  logic                             clr,
  bus_dest_loader_if.slave                 bif,
  input  logic [SEL_W-1:0]                 rd_sel,
  output logic [DATA_W-1:0]                rd_data,
  output logic [NUM_DEST-1:0][DATA_W-1:0]  reg_q
);
  state_e state, state_nxt;
  pend_t  pend, pend_nxt;
  logic   accept, commit, wr_err_q;
  logic [NUM_DEST-1:0]             ld;
  logic [NUM_DEST-1:0][DATA_W-1:0] regs;

  function automatic logic writable(input logic [SEL_W-1:0] s);
    writable = !RO_MASK[s];
`ifdef BUS_DEST_R0_ZERO_EN
    if (s == CODE_R0) writable = 1'b0;
`endif
  endfunction

  // Stage frees itself on the same edge it commits, so only a held entry blocks
  assign bif.wr_ready = (state == IDLE) || !bif.hold;
  assign accept       = bif.wr_valid && bif.wr_ready;
  assign commit       = (state == PEND) && !bif.hold;
  assign bif.busy     = (state == PEND);
  assign bif.wr_err   = wr_err_q;

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    case (state)
      IDLE: if (accept) begin
        state_nxt = PEND;
        pend_nxt  = '{sel: bif.wr_sel, data: bif.bus_data};
      end
      PEND: begin
        if (accept) pend_nxt = '{sel: bif.wr_sel, data: bif.bus_data};
        else if (commit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      pend     <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      pend     <= pend_nxt;
      wr_err_q <= accept && RO_MASK[bif.wr_sel];
    end
  end

  decoder_5_32 u_dec (
    .sel (pend.sel),
    .en  (commit && writable(pend.sel)),
    .ld  (ld)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) regs <= '0;
    else
      for (int i = 0; i < NUM_DEST; i++)
        if (ld[i]) regs[i] <= pend.data;
  end

  assign reg_q   = regs;
  assign rd_data = (bif.busy && pend.sel == rd_sel && writable(rd_sel)) ? pend.data : regs[rd_sel];
endmodule

// File: tb/tb_bus_dest_loader.sv
// Randomized + directed bench for bus_dest_loader against a behavioural model.
module tb_bus_dest_loader;
  localparam logic [31:0] RO = 32'h00CC_0000;
`ifdef BUS_DEST_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic clk = 1'b0, clr = 1'b0;
  logic [4:0] rd_sel = '0;
  logic [31:0] rd_data;
  logic [31:0][31:0] reg_q;
  bus_dest_loader_if #(.DATA_W(32), .SEL_W(5)) bif ();

  bus_dest_loader dut (.clk(clk), .clr(clr), .bif(bif), .rd_sel(rd_sel), .rd_data(rd_data), .reg_q(reg_q));

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  logic [31:0] mreg [32];
  bit          pv, eerr;
  logic [4:0]  psel;
  logic [31:0] pdata;

  function automatic bit wrt(input logic [4:0] s);
    return !RO[s] && !(R0Z && s == 5'd0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (mreg[i]) mreg[i] = '0;
    pv = 0; eerr = 0; psel = '0; pdata = '0;
  endtask

  // Spec-level view of one rising edge: commit old entry, then capture new one
  task automatic model_edge();
    bit rdy, acc;
    if (!clr) return;
    rdy = !pv || !bif.hold;
    acc = bif.wr_valid && rdy;
    if (pv && !bif.hold) begin
      if (wrt(psel)) mreg[psel] = pdata;
      pv = 0;
    end
    eerr = acc && RO[bif.wr_sel];
    if (acc) begin pv = 1; psel = bif.wr_sel; pdata = bif.bus_data; end
  endtask

  task automatic compare_all();
    logic [31:0] exp_rd;
    for (int i = 0; i < 32; i++) chk($sformatf("reg_q[%0d]", i), reg_q[i], mreg[i]);
    chk("busy", 32'(bif.busy), 32'(pv));
    chk("wr_ready", 32'(bif.wr_ready), 32'(!pv || !bif.hold));
    chk("wr_err", 32'(bif.wr_err), 32'(eerr));
    exp_rd = (pv && psel == rd_sel && wrt(rd_sel)) ? pdata : mreg[rd_sel];
    chk("rd_data", rd_data, exp_rd);
  endtask

  task automatic cyc(input bit v, input logic [4:0] s, input logic [31:0] d, input bit h, input logic [4:0] rs);
    bif.wr_valid = v; bif.wr_sel = s; bif.bus_data = d; bif.hold = h; rd_sel = rs;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    bif.wr_valid = 0; bif.wr_sel = '0; bif.bus_data = '0; bif.hold = 0;
    model_reset();
    @(negedge clk);
    compare_all();
    chk("rst wr_ready", 32'(bif.wr_ready), 32'd1);
    chk("rst busy", 32'(bif.busy), 32'd0);
    clr = 1'b1;

    // R5 write with bypass
    cyc(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd5);
    chk("r5 bypass", rd_data, 32'hDEAD_BEEF);
    chk("r5 not yet", reg_q[5], 32'h0);
    chk("r5 busy", 32'(bif.busy), 32'd1);
    cyc(0, 5'd0, 32'h0, 0, 5'd5);
    chk("r5 commit", reg_q[5], 32'hDEAD_BEEF);
    chk("r5 idle", 32'(bif.busy), 32'd0);

    // PC held three cycles while MDR is offered
    cyc(1, 5'd20, 32'h100, 0, 5'd20);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 5'd21, 32'h55, 1, 5'd21);
      chk("held ready", 32'(bif.wr_ready), 32'd0);
      chk("held pc", reg_q[20], 32'h0);
    end
    cyc(1, 5'd21, 32'h55, 0, 5'd21);
    chk("pc commit", reg_q[20], 32'h100);
    chk("mdr pend", reg_q[21], 32'h0);
    cyc(0, 5'd0, 32'h0, 0, 5'd21);
    chk("mdr commit", reg_q[21], 32'h55);

    // Read-only ZLO
    cyc(1, 5'd19, 32'h1234, 0, 5'd19);
    chk("zlo err", 32'(bif.wr_err), 32'd1);
    cyc(0, 5'd0, 32'h0, 0, 5'd19);
    chk("zlo err once", 32'(bif.wr_err), 32'd0);
    chk("zlo kept", reg_q[19], 32'h0);

    // Back-to-back to R31
    cyc(1, 5'd31, 32'h1, 0, 5'd31);
    cyc(1, 5'd31, 32'h2, 0, 5'd31);
    cyc(0, 5'd0, 32'h0, 0, 5'd31);
    chk("r31 last", reg_q[31], 32'h2);

    // Reset before commit discards the entry
    cyc(1, 5'd7, 32'hAA, 0, 5'd7);
    bif.wr_valid = 0;
    clr = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("rst busy mid", 32'(bif.busy), 32'd0);
    clr = 1'b1;
    cyc(0, 5'd0, 32'h0, 0, 5'd7);
    chk("r7 dropped", reg_q[7], 32'h0);

    // R0 write
    cyc(1, 5'd0, 32'hFF, 0, 5'd0);
    chk("r0 no err", 32'(bif.wr_err), 32'd0);
    cyc(0, 5'd0, 32'h0, 0, 5'd0);
    chk("r0 value", reg_q[0], R0Z ? 32'h0 : 32'hFF);

    // Random traffic with occasional asynchronous reset
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        clr = 1'b0;
        model_reset();
        #1;
        compare_all();
        clr = 1'b1;
      end
      cyc(1'($urandom_range(0, 2) != 0), 5'($urandom), $urandom,
          1'($urandom_range(0, 2) == 0), 5'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/bus_dest_loader.md
Name: bus_dest_loader

Overview:
- Destination side of the 32-source datapath bus: takes the bus value plus a 5-bit destination code and loads it into one of 32 destination registers.
- Destination codes are the same as the bus source-select codes:
  - 0-15: R0-R15
  - 16: HI, 17: LO, 18: ZHI, 19: ZLO
  - 20: PC, 21: MDR, 22: InPort, 23: C
  - 24-31: R24-R31
- Accepts writes through a valid/ready handshake into a one-entry pending stage, then commits on the next edge unless held.
- Register contents drive the bus multiplexer inputs; one read port with bypass is provided for control/debug.

Parameters:
- DATA_W, 32, bus and register width
- NUM_DEST, 32, number of destination registers
- SEL_W, 5, destination/read select width
- RO_MASK, 32'h00CC_0000, bit i set means code i is not bus-writable (ZHI, ZLO, InPort, C)

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous active-low reset
- bus_data  in  DATA_W  current bus value (BusMuxOut)
- wr_valid  in  1  write request
- wr_sel  in  SEL_W  destination code
- wr_ready  out  1  pending stage can accept a write
- hold  in  1  stall commit of the pending entry
- rd_sel  in  SEL_W  read port select
- rd_data  out  DATA_W  read port data, with bypass
- reg_q  out  NUM_DEST*DATA_W  flattened register contents; slice i = code i; feeds the bus mux
- wr_err  out  1  one-cycle pulse on an accepted write to a read-only code
- busy  out  1  pending entry valid

Behaviour:
- Reset (clr=0, asynchronous): all registers 0, pending entry invalid (state IDLE), wr_ready=1, wr_err=0, busy=0.
- States:
  - IDLE: no pending entry.
  - PEND: one entry held as {sel, data}.
- Accept: a write is accepted when wr_valid & wr_ready at a rising edge. bus_data and wr_sel are captured at that edge; later bus changes have no effect.
- Commit: in PEND with hold=0, the entry is written into register[sel] at the next edge.
  - Load latency: accept at edge N, visible on reg_q after edge N+1 (no hold).
- wr_ready:
  - 1 in IDLE.
  - 1 in PEND when hold=0 (commit and accept happen on the same edge; the new entry replaces the old one, state stays PEND).
  - 0 in PEND when hold=1.
- Transitions:
  - IDLE -> PEND on accept.
  - PEND -> IDLE on commit with no accept.
  - PEND -> PEND on accept + commit, or while hold=1.
- Read-only codes (RO_MASK bit set):
  - The write is still accepted (handshake completes) and the pending stage is still used.
  - No register changes on commit.
  - wr_err pulses for exactly the cycle after the accept edge.
- Write conflicts: back-to-back writes to the same code commit in order; last value wins.
- rd_data (combinational):
  - If busy, pending sel == rd_sel and that code is writable: returns the pending data (bypass).
  - Otherwise returns register[rd_sel].
- reg_q: never bypassed; shows committed state only.
- Mid-operation reset: clr low discards the pending entry immediately; no commit occurs.
- busy equals state==PEND.
- wr_sel is always in range (5 bits, 32 codes); no out-of-range case exists.

Optional Feature:
- Macro: BUS_DEST_R0_ZERO_EN.
- Defined:
  - Register 0 is never written; commits to code 0 are dropped and do not raise wr_err.
  - reg_q slice 0 and rd_data for rd_sel=0 always read 0; bypass is suppressed for code 0.
  - Supports base+offset addressing with R0 as a constant-zero base.
- Undefined: R0 is an ordinary writable register.

Decomposition:
- Shared package bus_codes_pkg holds:
  - DATA_W, SEL_W, NUM_DEST
  - localparams for every destination code (CODE_R0..CODE_R15, CODE_HI, CODE_LO, CODE_ZHI, CODE_ZLO, CODE_PC, CODE_MDR, CODE_INPORT, CODE_C, CODE_R24..CODE_R31)
  - RO_MASK default
  - the state enum {IDLE, PEND}
- Sub-module decoder_5_32: combinational 5-to-32 one-hot decode of the pending sel, gated by commit, producing per-register load enables. It is the inverse of the bus source encoder.

Test Plan:
- Reset: after clr low then high, every reg_q slice = 0, wr_ready=1, busy=0, wr_err=0.
- Write R5 = 32'hDEAD_BEEF at edge N:
  - After N, busy=1 and rd_sel=5 returns DEAD_BEEF via bypass while reg_q[5] is still 0.
  - After N+1, reg_q[5]=DEAD_BEEF and busy=0.
- Hold: write PC(20)=32'h100, hold=1 for 3 cycles, then a second write of MDR(21)=32'h55 is offered:
  - wr_ready=0 while held and reg_q[20] unchanged.
  - hold drop: PC=100 commits and MDR is accepted on the same edge; MDR=55 commits one cycle later.
- Read-only: write ZLO(19)=32'h1234 -> handshake completes, wr_err pulses once, reg_q[19] stays 0.
- Back-to-back: R31=1 then R31=2 on consecutive edges -> final reg_q[31]=2, no dropped handshakes.
- Reset mid-flight, then R0 behaviour:
  - Accept R7=32'hAA, assert clr before the commit edge -> reg_q[7]=0, busy=0.
  - With BUS_DEST_R0_ZERO_EN, a write R0=32'hFF leaves reg_q[0]=0 and no wr_err.
